scr_write_queue: RTL and testbench
==================================

Name: scr_write_queue

Overview:
- Host-side write path into screen RAM port B, directly upstream of the screen RAM / display controllers.
- Holds a screen address pointer with optional auto-increment.
- Buffers host byte writes as {address, data} pairs in a FIFO.
- Drains the FIFO into screen RAM only when the display grants a free slot, so host writes never disturb scan-out reads.

Parameters:
- ADDR_W, 16, screen RAM address width.
- DATA_W, 8, screen RAM data width.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries.

Ports:
- clk  in  1  system clock (fclock domain); all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_load  in  1  pulse: load address pointer from addr_in.
- addr_in  in  ADDR_W  new pointer value.
- auto_inc_en  in  1  1 = pointer +1 after each accepted write.
- wr_req  in  1  pulse: enqueue write of wr_data at current pointer.
- wr_data  in  DATA_W  write byte.
- ovf_clr  in  1  pulse: clear overflow flag.
- ram_grant  in  1  1 = RAM port B slot available this cycle.
- ram_addr  out  ADDR_W  RAM write address (registered).
- ram_data  out  DATA_W  RAM write data (registered).
- ram_wren  out  1  RAM write strobe (registered, 1-cycle).
- cur_addr  out  ADDR_W  current pointer value.
- level  out  DEPTH_LOG2+1  FIFO occupancy.
- full  out  1  level == 2**DEPTH_LOG2.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset: async on rst high; cur_addr=0, FIFO pointers=0, level=0, empty=1, full=0, overflow=0, ram_wren=0, ram_addr=0, ram_data=0.
- Pointer:
  - addr_load at edge → cur_addr=addr_in.
  - Accepted wr_req with auto_inc_en=1 → cur_addr+1, wrapping 2**ADDR_W-1 → 0.
  - auto_inc_en=0 → pointer unchanged.
- addr_load and wr_req same cycle: entry uses addr_in; cur_addr becomes addr_in+1 (auto_inc_en=1) or addr_in.
- Push: wr_req with full=0 (pre-edge level) writes {effective address, wr_data} at tail.
- Push when full: entry dropped, pointer unchanged, overflow set.
  - Push is rejected when full even if a pop occurs the same cycle.
- Pop: at edge where empty=0 and ram_grant=1, head entry removed; same edge registers ram_addr/ram_data and sets ram_wren=1 for exactly one cycle.
  - Otherwise ram_wren=0; ram_addr/ram_data hold their last values.
- Pop rate: at most one pop per cycle; continuous grant drains one entry per cycle.
- Push and pop in the same cycle: level unchanged, both complete.
- Latency: wr_req sampled at edge N into an empty FIFO with ram_grant=1 at N+1 → ram_wren high during cycle after edge N+1 (2 edges).
- FIFO order: strict FIFO; write pointers wrap modulo depth.
- ram_grant low: entries held indefinitely; no loss.
- overflow:
  - Cleared by ovf_clr.
  - Same-cycle overflow event and ovf_clr → overflow=1 (set wins).
- Reset mid-drain: pending entries discarded; ram_wren forced 0 immediately (async).

Optional Feature:
- Macro SCR_WRQ_FILL_EN.
- Defined: adds ports fill_req in 1, fill_count in ADDR_W, busy out 1.
  - fill_req (when busy=0) latches wr_data and fill_count; busy=1.
  - Block then self-issues pushes of the latched byte at successive pointer addresses. Pointer always increments in fill, regardless of auto_inc_en.
  - One push per cycle while full=0; stalls (no overflow) while full.
  - busy=0 the cycle after the final push.
  - fill_count=0 → no pushes; busy pulses for one cycle.
  - While busy: host wr_req is dropped and sets overflow; addr_load is ignored.
- Undefined: ports absent; behaviour as above.

Test Plan:
- Reset, addr_load addr_in=0x1000, auto_inc_en=1, 3 wr_req (0xAA, 0xBB, 0xCC), ram_grant=1 → ram_wren on 3 consecutive cycles: (0x1000,0xAA), (0x1001,0xBB), (0x1002,0xCC); cur_addr=0x1003.
- ram_grant=0, 17 wr_req with DEPTH_LOG2=4 → level=16, full=1, overflow=1, 17th byte absent. Then grant=1 → exactly 16 ram_wren in order. ovf_clr → overflow=0.
- addr_in=0xFFFF, auto_inc_en=1, 2 writes → ram_addr 0xFFFF then 0x0000.
- addr_load addr_in=0x0200 plus wr_req 0x55 same cycle, auto_inc_en=0 → entry at 0x0200; cur_addr=0x0200.
- 8 entries queued, grant=0, rst pulse mid-sequence → level=0, empty=1, ram_wren=0 immediately. Post-reset grant=1 → no ram_wren.
- SCR_WRQ_FILL_EN: cur_addr=0x0400, wr_data=0x20, fill_count=20, grant toggling 1/0 → exactly 20 writes of 0x20 to 0x0400..0x0413; overflow stays 0; busy drops after last push.

Source files
------------

// File: rtl/scr_write_queue_if.sv
// rtl/scr_write_queue_if.sv - host and screen-RAM signal bundle for scr_write_queue
//
// Purpose: groups the host write-request signals, status outputs and the
//          screen RAM port B write signals of scr_write_queue.
// Modports:
//   slave  - the queue itself (receives host requests, drives RAM + status)
//   master - the host / test driver side
// Signals:
//   addr_load, addr_in, auto_inc_en : address pointer control
//   wr_req, wr_data                 : host byte write request
//   ovf_clr                         : clear sticky overflow
//   ram_grant                       : RAM port B slot free this cycle
//   ram_addr, ram_data, ram_wren    : registered RAM write
//   cur_addr, level, full, empty, overflow : status
//   fill_req, fill_count, busy      : block fill (only with SCR_WRQ_FILL_EN)
interface scr_write_queue_if #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic                  addr_load;
   logic [ADDR_W-1:0]     addr_in;
   logic                  auto_inc_en;
   logic                  wr_req;
   logic [DATA_W-1:0]     wr_data;
   logic                  ovf_clr;
   logic                  ram_grant;
   logic [ADDR_W-1:0]     ram_addr;
   logic [DATA_W-1:0]     ram_data;
   logic                  ram_wren;
   logic [ADDR_W-1:0]     cur_addr;
   logic [DEPTH_LOG2:0]   level;
   logic                  full;
   logic                  empty;
   logic                  overflow;
`ifdef SCR_WRQ_FILL_EN
   logic                  fill_req;
   logic [ADDR_W-1:0]     fill_count;
   logic                  busy;
`endif

   modport slave (
      input  addr_load, addr_in, auto_inc_en, wr_req, wr_data, ovf_clr, ram_grant,
`ifdef SCR_WRQ_FILL_EN
      input  fill_req, fill_count,
      output busy,
`endif
      output ram_addr, ram_data, ram_wren, cur_addr, level, full, empty, overflow
   );

   modport master (
      output addr_load, addr_in, auto_inc_en, wr_req, wr_data, ovf_clr, ram_grant,
`ifdef SCR_WRQ_FILL_EN
      output fill_req, fill_count,
      input  busy,
`endif
      input  ram_addr, ram_data, ram_wren, cur_addr, level, full, empty, overflow
   );
endinterface

// File: rtl/scr_write_queue.sv
// rtl/scr_write_queue.sv - buffered host write path into screen RAM port B
//
// Purpose: keeps a screen address pointer (optional auto-increment), queues
//          host byte writes as {address, data} entries and drains them into
//          screen RAM only on cycles where the display grants a free slot.
// Optional feature macro: SCR_WRQ_FILL_EN (block fill engine: fill_req,
//          fill_count, busy on the interface).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - scr_write_queue_if.slave (host controls, RAM write, status)
module scr_write_queue #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rst,
   scr_write_queue_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W-1:0]     ADR_ONE  = 1;

   logic [ENT_W-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   level_q;
   logic [ADDR_W-1:0]     cur_addr_q;
   logic                  overflow_q;
   logic [ADDR_W-1:0]     ram_addr_q;
   logic [DATA_W-1:0]     ram_data_q;
   logic                  ram_wren_q;

   logic                  full_w, empty_w;
   logic                  busy, fill_push;
   logic [DATA_W-1:0]     push_data;
   logic                  host_load, host_push, push_ok, pop, ovf_set, step;
   logic [ADDR_W-1:0]     eff_addr;

   assign full_w  = (level_q == LVL_FULL);
   assign empty_w = (level_q == '0);

`ifdef SCR_WRQ_FILL_EN
   logic                  busy_q;
   logic [DATA_W-1:0]     fill_data_q;
   logic [ADDR_W-1:0]     fill_remain_q;

   assign busy      = busy_q;
   // Fill stalls on full instead of dropping, so it never raises overflow.
   assign fill_push = busy_q && (fill_remain_q != '0) && !full_w;
   assign push_data = busy_q ? fill_data_q : bus.wr_data;
   assign bus.busy  = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q        <= 1'b0;
         fill_data_q   <= '0;
         fill_remain_q <= '0;
      end else if (!busy_q) begin
         if (bus.fill_req) begin
            busy_q        <= 1'b1;
            fill_data_q   <= bus.wr_data;
            fill_remain_q <= bus.fill_count;
         end
      end else if (fill_remain_q == '0) begin
         // Zero-length fill: busy is visible for exactly one cycle.
         busy_q <= 1'b0;
      end else if (fill_push) begin
         fill_remain_q <= fill_remain_q - ADR_ONE;
         if (fill_remain_q == ADR_ONE) busy_q <= 1'b0;
      end
   end
`else
   assign busy      = 1'b0;
   assign fill_push = 1'b0;
   assign push_data = bus.wr_data;
`endif

   // Host requests are locked out while a fill owns the pointer.
   assign host_load = bus.addr_load && !busy;
   assign host_push = bus.wr_req && !busy;
   // A same-cycle load redirects the entry being pushed to addr_in.
   assign eff_addr  = host_load ? bus.addr_in : cur_addr_q;
   // Pre-edge full decides acceptance, even if a pop frees a slot this edge.
   assign push_ok   = (host_push || fill_push) && !full_w;
   assign pop       = !empty_w && bus.ram_grant;
   assign ovf_set   = bus.wr_req && (busy || full_w);
   assign step      = busy || bus.auto_inc_en;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {eff_addr, push_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         cur_addr_q <= '0;
         overflow_q <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_wren_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            cur_addr_q <= step ? eff_addr + ADR_ONE : eff_addr;
         end else if (host_load) begin
            cur_addr_q <= bus.addr_in;
         end

         if (pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            ram_addr_q <= mem[rd_ptr][ENT_W-1:DATA_W];
            ram_data_q <= mem[rd_ptr][DATA_W-1:0];
            ram_wren_q <= 1'b1;
         end else begin
            ram_wren_q <= 1'b0;
         end

         case ({push_ok, pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase

         // Set has priority over clear.
         if (ovf_set)          overflow_q <= 1'b1;
         else if (bus.ovf_clr) overflow_q <= 1'b0;
      end
   end

   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_data = ram_data_q;
   assign bus.ram_wren = ram_wren_q;
   assign bus.cur_addr = cur_addr_q;
   assign bus.level    = level_q;
   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_scr_write_queue.sv
// tb/tb_scr_write_queue.sv - directed self-checking bench for scr_write_queue
module tb_scr_write_queue;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;

   logic [15:0] cap_addr [$];
   logic [7:0]  cap_data [$];
   int          cap_cyc  [$];

   scr_write_queue_if #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(4)) bus ();

   scr_write_queue #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (bus.ram_wren === 1'b1) begin
         cap_addr.push_back(bus.ram_addr);
         cap_data.push_back(bus.ram_data);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cap_clear();
      cap_addr.delete();
      cap_data.delete();
      cap_cyc.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      bus.addr_load   = 1'b0;
      bus.addr_in     = '0;
      bus.auto_inc_en = 1'b0;
      bus.wr_req      = 1'b0;
      bus.wr_data     = '0;
      bus.ovf_clr     = 1'b0;
      bus.ram_grant   = 1'b0;
`ifdef SCR_WRQ_FILL_EN
      bus.fill_req    = 1'b0;
      bus.fill_count  = '0;
`endif
      tick();
      tick();
      chk("rst_cur_addr", 32'(bus.cur_addr), 32'h0);
      chk("rst_level",    32'(bus.level),    32'h0);
      chk("rst_empty",    32'(bus.empty),    32'h1);
      chk("rst_full",     32'(bus.full),     32'h0);
      chk("rst_overflow", 32'(bus.overflow), 32'h0);
      chk("rst_wren",     32'(bus.ram_wren), 32'h0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
      chk("rst_ram_data", 32'(bus.ram_data), 32'h0);
      rst = 1'b0;

      // Three auto-incrementing writes with grant always on
      cap_clear();
      bus.addr_load = 1'b1; bus.addr_in = 16'h1000; bus.auto_inc_en = 1'b1; bus.ram_grant = 1'b1;
      tick();
      bus.addr_load = 1'b0; bus.wr_req = 1'b1; bus.wr_data = 8'hAA;
      tick();
      chk("lat_wren_after_1_edge", 32'(bus.ram_wren), 32'h0);
      bus.wr_data = 8'hBB;
      tick();
      chk("lat_wren_after_2_edges", 32'(bus.ram_wren), 32'h1);
      bus.wr_data = 8'hCC;
      tick();
      bus.wr_req = 1'b0;
      repeat (4) tick();
      chk("t1_count", 32'(cap_addr.size()), 32'd3);
      if (cap_addr.size() == 3) begin
         chk("t1_a0", 32'(cap_addr[0]), 32'h1000); chk("t1_d0", 32'(cap_data[0]), 32'hAA);
         chk("t1_a1", 32'(cap_addr[1]), 32'h1001); chk("t1_d1", 32'(cap_data[1]), 32'hBB);
         chk("t1_a2", 32'(cap_addr[2]), 32'h1002); chk("t1_d2", 32'(cap_data[2]), 32'hCC);
         chk("t1_consec1", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
         chk("t1_consec2", 32'(cap_cyc[2] - cap_cyc[1]), 32'd1);
      end
      chk("t1_cur_addr", 32'(bus.cur_addr), 32'h1003);

      // Fill to full with grant off; 17th write dropped while ovf_clr is also high
      bus.ram_grant = 1'b0;
      bus.addr_load = 1'b1; bus.addr_in = 16'h2000;
      tick();
      bus.addr_load = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.wr_req  = 1'b1;
         bus.wr_data = 8'(8'h10 + i);
         bus.ovf_clr = (i == 16);
         tick();
      end
      bus.wr_req = 1'b0; bus.ovf_clr = 1'b0;
      chk("t2_level",    32'(bus.level),    32'd16);
      chk("t2_full",     32'(bus.full),     32'h1);
      chk("t2_overflow_set_wins", 32'(bus.overflow), 32'h1);
      chk("t2_cur_addr", 32'(bus.cur_addr), 32'h2010);
      // Push while full with a simultaneous pop is still rejected
      cap_clear();
      bus.ram_grant = 1'b1; bus.wr_req = 1'b1; bus.wr_data = 8'hEE;
      tick();
      bus.ram_grant = 1'b0; bus.wr_req = 1'b0;
      chk("t2_full_pop_level", 32'(bus.level),    32'd15);
      chk("t2_full_pop_addr",  32'(bus.cur_addr), 32'h2010);
      bus.ram_grant = 1'b1;
      repeat (20) tick();
      chk("t2_drain_count", 32'(cap_addr.size()), 32'd16);
      for (int i = 0; i < 16 && i < cap_addr.size(); i++) begin
         chk($sformatf("t2_a%0d", i), 32'(cap_addr[i]), 32'h2000 + 32'(i));
         chk($sformatf("t2_d%0d", i), 32'(cap_data[i]), 32'h10 + 32'(i));
      end
      chk("t2_empty", 32'(bus.empty), 32'h1);
      chk("t2_overflow_before_clr", 32'(bus.overflow), 32'h1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("t2_overflow_clr", 32'(bus.overflow), 32'h0);

      // Pointer wrap at top of address space
      cap_clear();
      bus.addr_load = 1'b1; bus.addr_in = 16'hFFFF;
      tick();
      bus.addr_load = 1'b0; bus.wr_req = 1'b1; bus.wr_data = 8'h01;
      tick();
      bus.wr_data = 8'h02;
      tick();
      bus.wr_req = 1'b0;
      repeat (4) tick();
      chk("t3_count", 32'(cap_addr.size()), 32'd2);
      if (cap_addr.size() == 2) begin
         chk("t3_a0", 32'(cap_addr[0]), 32'hFFFF);
         chk("t3_a1", 32'(cap_addr[1]), 32'h0000);
      end
      chk("t3_cur_addr", 32'(bus.cur_addr), 32'h0001);

      // Load and write in the same cycle, no auto-increment
      cap_clear();
      bus.auto_inc_en = 1'b0;
      bus.addr_load = 1'b1; bus.addr_in = 16'h0200; bus.wr_req = 1'b1; bus.wr_data = 8'h55;
      tick();
      bus.addr_load = 1'b0; bus.wr_req = 1'b0;
      repeat (3) tick();
      chk("t4_count", 32'(cap_addr.size()), 32'd1);
      if (cap_addr.size() == 1) begin
         chk("t4_a0", 32'(cap_addr[0]), 32'h0200);
         chk("t4_d0", 32'(cap_data[0]), 32'h55);
      end
      chk("t4_cur_addr", 32'(bus.cur_addr), 32'h0200);

      // Asynchronous reset in the middle of a drain
      bus.auto_inc_en = 1'b1; bus.ram_grant = 1'b0;
      bus.addr_load = 1'b1; bus.addr_in = 16'h3000;
      tick();
      bus.addr_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.wr_req = 1'b1; bus.wr_data = 8'(8'h80 + i);
         tick();
      end
      bus.wr_req = 1'b0;
      chk("t5_level8", 32'(bus.level), 32'd8);
      bus.ram_grant = 1'b1;
      tick();
      chk("t5_wren_pre_rst", 32'(bus.ram_wren), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_wren",  32'(bus.ram_wren), 32'h0);
      chk("t5_rst_level", 32'(bus.level),    32'h0);
      chk("t5_rst_empty", 32'(bus.empty),    32'h1);
      tick();
      rst = 1'b0;
      cap_clear();
      repeat (5) tick();
      chk("t5_post_rst_no_wren", 32'(cap_addr.size()), 32'd0);

`ifdef SCR_WRQ_FILL_EN
      // Block fill: zero-length first, then 20 bytes with grant toggling
      bus.ram_grant = 1'b0; bus.auto_inc_en = 1'b0;
      bus.addr_load = 1'b1; bus.addr_in = 16'h0400;
      tick();
      bus.addr_load = 1'b0;
      bus.fill_req = 1'b1; bus.fill_count = 16'd0;
      tick();
      bus.fill_req = 1'b0;
      chk("f0_busy_high", 32'(bus.busy), 32'h1);
      tick();
      chk("f0_busy_low", 32'(bus.busy),  32'h0);
      chk("f0_level",    32'(bus.level), 32'h0);
      cap_clear();
      bus.fill_req = 1'b1; bus.fill_count = 16'd20; bus.wr_data = 8'h20;
      tick();
      bus.fill_req = 1'b0;
      chk("f1_busy", 32'(bus.busy), 32'h1);
      for (int i = 0; i < 300; i++) begin
         if (!bus.busy && bus.empty) break;
         bus.ram_grant = i[0];
         tick();
      end
      chk("f1_busy_done", 32'(bus.busy),  32'h0);
      chk("f1_empty",     32'(bus.empty), 32'h1);
      bus.ram_grant = 1'b0;
      tick();
      chk("f1_count", 32'(cap_addr.size()), 32'd20);
      for (int i = 0; i < 20 && i < cap_addr.size(); i++) begin
         chk($sformatf("f1_a%0d", i), 32'(cap_addr[i]), 32'h0400 + 32'(i));
         chk($sformatf("f1_d%0d", i), 32'(cap_data[i]), 32'h20);
      end
      chk("f1_overflow", 32'(bus.overflow), 32'h0);
      chk("f1_cur_addr", 32'(bus.cur_addr), 32'h0414);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
